// File: rtl/demux2_64bit_stream_if.sv
// Stream bundle for demux2_64bit_stream: one input channel, two output channels.
// slave  : the demux side (consumes In, produces o0/o1).
// master : the producer/consumer side that drives the demux.
interface demux2_64bit_stream_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] In;
    logic             in_valid;
    logic             select;
    logic             in_ready;
    logic [WIDTH-1:0] o0;
    logic             o0_valid;
    logic             o0_ready;
    logic [WIDTH-1:0] o1;
    logic             o1_valid;
    logic             o1_ready;

    modport slave (
        input  In, in_valid, select, o0_ready, o1_ready,
        output in_ready, o0, o0_valid, o1, o1_valid
    );

    modport master (
        output In, in_valid, select, o0_ready, o1_ready,
        input  in_ready, o0, o0_valid, o1, o1_valid
    );
endinterface

// File: rtl/demux2_64bit_stream.sv
// Registered 1-to-2 demultiplexer for a 64-bit valid/ready stream.
// Each beat goes to o0 or o1 according to its select bit; each output has one
// holding register, and in_ready looks only at the selected channel so a stalled
// consumer never blocks traffic headed for the other one.
// Optional macro DEMUX2_64BIT_CNT_EN: when defined, per-channel accepted-beat
// counters drive cnt0/cnt1; otherwise both are tied to zero.
module demux2_64bit_stream #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux2_64bit_stream_if.slave  bus,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      st0_q, st0_d;
    chan_state_t      st1_q, st1_d;
    logic [WIDTH-1:0] d0_q, d1_q;
    logic             rdy;
    logic             load0, load1;
    logic             drain0, drain1;

    // Handshake decode: acceptance depends only on the selected channel's slot.
    always_comb begin
        drain0 = (st0_q == FULL) && bus.o0_ready;
        drain1 = (st1_q == FULL) && bus.o1_ready;
        if (bus.select) begin
            rdy = (st1_q == EMPTY) || bus.o1_ready;
        end else begin
            rdy = (st0_q == EMPTY) || bus.o0_ready;
        end
        load0 = bus.in_valid && rdy && !bus.select;
        load1 = bus.in_valid && rdy &&  bus.select;
    end

    // Per-channel next state: a load always fills, a drain without load empties.
    always_comb begin
        st0_d = st0_q;
        st1_d = st1_q;
        if (load0) begin
            st0_d = FULL;
        end else if (drain0) begin
            st0_d = EMPTY;
        end
        if (load1) begin
            st1_d = FULL;
        end else if (drain1) begin
            st1_d = EMPTY;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q <= EMPTY;
            st1_q <= EMPTY;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
        end
    end

    // Holding registers: capture the beat on load, otherwise keep the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            if (load0) begin
                d0_q <= bus.In;
            end
            if (load1) begin
                d1_q <= bus.In;
            end
        end
    end

    // Drive the bus outputs from the registered state.
    always_comb begin
        bus.in_ready = rdy;
        bus.o0       = d0_q;
        bus.o1       = d1_q;
        bus.o0_valid = (st0_q == FULL);
        bus.o1_valid = (st1_q == FULL);
    end

`ifdef DEMUX2_64BIT_CNT_EN
    // Accepted-beat counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (load1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`else
    // Counters not built: report zero.
    always_comb begin
        cnt0 = '0;
        cnt1 = '0;
    end
`endif

endmodule

// File: tb/tb_demux2_64bit_stream.sv
// Self-checking bench for demux2_64bit_stream (CNT_W=4 so the wrap is reachable).
module tb_demux2_64bit_stream;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] cnt0, cnt1;
    int            total;
    int            bad;

    demux2_64bit_stream_if #(.WIDTH(W)) bus ();

    demux2_64bit_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cnt0  (cnt0),
        .cnt1  (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        sel;
        logic [63:0] d;
        logic        r0;
        logic        r1;
        logic        exp_rdy;
        logic        ev0;
        logic        ev1;
        logic [63:0] eo0;
        logic [63:0] eo1;
        int          c0;
        int          c1;
    } vec_t;

    vec_t        tbl [8];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          n0, n1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef DEMUX2_64BIT_CNT_EN
        return CW'(n % (1 << CW));
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic iv, input logic sel, input logic [63:0] d,
                         input logic r0, input logic r1);
        bus.in_valid = iv;
        bus.select   = sel;
        bus.In       = d;
        bus.o0_ready = r0;
        bus.o1_ready = r1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        n0 = 0;
        n1 = 0;
    endtask

    // One randomized cycle checked against the queue-based scoreboard.
    task automatic rnd_step(input bit allow_in, input bit force_ready);
        logic        iv, sel, r0, r1, er;
        logic [63:0] d;
        @(negedge clk);
        iv  = allow_in && ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 1) != 0;
        d   = {$urandom, $urandom};
        r0  = force_ready || ($urandom_range(0, 9) < 7);
        r1  = force_ready || ($urandom_range(0, 9) < 6);
        drive(iv, sel, d, r0, r1);
        #1;
        er = sel ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
        chk("rnd_in_ready", 64'(bus.in_ready), 64'(er));
        chk("rnd_o0_valid", 64'(bus.o0_valid), 64'(q0.size() != 0));
        chk("rnd_o1_valid", 64'(bus.o1_valid), 64'(q1.size() != 0));
        if (q0.size() != 0 && r0) begin
            chk("rnd_o0_data", bus.o0, q0[0]);
            void'(q0.pop_front());
        end
        if (q1.size() != 0 && r1) begin
            chk("rnd_o1_data", bus.o1, q1[0]);
            void'(q1.pop_front());
        end
        if (iv && er) begin
            if (sel) begin
                q1.push_back(d);
                n1++;
            end else begin
                q0.push_back(d);
                n0++;
            end
        end
        @(posedge clk);
        #1;
        chk("rnd_cnt0", 64'(cnt0), 64'(exp_cnt(n0)));
        chk("rnd_cnt1", 64'(cnt1), 64'(exp_cnt(n1)));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n0    = 0;
        n1    = 0;

        //             iv    sel   d                        r0    r1    rdy   v0    v1    o0                       o1     c0 c1
        tbl[0] = '{1'b1, 1'b0, 64'd7,                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd7,                   64'd0,  1, 0};
        tbl[1] = '{1'b0, 1'b0, 64'd0,                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd7,                   64'd0,  1, 0};
        tbl[2] = '{1'b1, 1'b1, 64'd12,                  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'd7,                   64'd12, 1, 1};
        tbl[3] = '{1'b1, 1'b1, 64'd99,                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd7,                   64'd12, 1, 1};
        tbl[4] = '{1'b1, 1'b0, 64'd5,                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd5,                   64'd12, 2, 1};
        tbl[5] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12, 3, 1};
        tbl[6] = '{1'b1, 1'b0, 64'd3,                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12, 3, 1};
        tbl[7] = '{1'b0, 1'b1, 64'd0,                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12, 3, 1};

        // Reset held with in_valid asserted.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 64'd7, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o0_valid", 64'(bus.o0_valid), 64'd0);
        chk("rst_o1_valid", 64'(bus.o1_valid), 64'd0);
        chk("rst_o0", bus.o0, 64'd0);
        chk("rst_o1", bus.o1, 64'd0);
        chk("rst_cnt0", 64'(cnt0), 64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed table: route, drain, backpressure, no HOL block, drain+load.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_o0_valid", i), 64'(bus.o0_valid), 64'(tbl[i].ev0));
            chk($sformatf("tbl%0d_o1_valid", i), 64'(bus.o1_valid), 64'(tbl[i].ev1));
            chk($sformatf("tbl%0d_o0", i), bus.o0, tbl[i].eo0);
            chk($sformatf("tbl%0d_o1", i), bus.o1, tbl[i].eo1);
            chk($sformatf("tbl%0d_cnt0", i), 64'(cnt0), 64'(exp_cnt(tbl[i].c0)));
            chk($sformatf("tbl%0d_cnt1", i), 64'(cnt1), 64'(exp_cnt(tbl[i].c1)));
        end

        // Asynchronous reset between clock edges while channel 1 holds a beat.
        apply_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 64'd12, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_pre_o1_valid", 64'(bus.o1_valid), 64'd1);
        chk("mid_pre_cnt1", 64'(cnt1), 64'(exp_cnt(1)));
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_o1_valid", 64'(bus.o1_valid), 64'd0);
        chk("mid_o1", bus.o1, 64'd0);
        chk("mid_cnt1", 64'(cnt1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 64'd7, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("mid_post_o0", bus.o0, 64'd7);
        chk("mid_post_o0_valid", 64'(bus.o0_valid), 64'd1);
        chk("mid_post_cnt0", 64'(cnt0), 64'(exp_cnt(1)));

        // Counter wrap: 16 back-to-back beats into channel 1.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 64'(i), 1'b1, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_cnt1", i), 64'(cnt1), 64'(exp_cnt(i + 1)));
            chk($sformatf("wrap%0d_cnt0", i), 64'(cnt0), 64'd0);
        end
        chk("wrap_o1", bus.o1, 64'd15);

        // Randomized traffic against the scoreboard, then drain.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            rnd_step(1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            rnd_step(1'b0, 1'b1);
        end
        chk("rnd_q0_empty", 64'(q0.size()), 64'd0);
        chk("rnd_q1_empty", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux2_64bit_stream.md
Name: demux2_64bit_stream

Overview:
- Registered 1-to-2 demultiplexer for 64-bit data. It is the split-side counterpart of the team's 2:1 64-bit mux.
- Routes each input beat to output 0 or 1 according to a per-beat select.
- Valid/ready handshake on the input and on both outputs; one holding register per output.
- Used wherever a single 64-bit stream fans out to two consumers that may stall independently.

Parameters:
- WIDTH, 64, data width of In, o0, o1.
- CNT_W, 16, width of the per-channel accepted-beat counters.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- In  input  WIDTH  input data beat.
- in_valid  input  1  In/select are valid this cycle.
- select  input  1  destination of the current beat: 0 -> o0, 1 -> o1.
- in_ready  output  1  block accepts the beat this cycle.
- o0  output  WIDTH  channel 0 data.
- o0_valid  output  1  o0 holds an undelivered beat.
- o0_ready  input  1  channel 0 consumer accepts.
- o1  output  WIDTH  channel 1 data.
- o1_valid  output  1  o1 holds an undelivered beat.
- o1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  beats accepted into channel 0.
- cnt1  output  CNT_W  beats accepted into channel 1.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): o0=o1=0, o0_valid=o1_valid=0, cnt0=cnt1=0. Any held beats are discarded.
- After reset is released, state updates only on the rising edge of clk.
- Per channel k, two states:
  - EMPTY (ok_valid=0) -> FULL on load.
  - FULL (ok_valid=1) -> EMPTY on drain with no load.
  - FULL stays FULL on drain plus load (data replaced), or when neither drain nor load occurs.
- Drain_k = ok_valid && ok_ready.
- in_ready is combinational:
  - select=0: in_ready = !o0_valid || o0_ready.
  - select=1: in_ready = !o1_valid || o1_ready.
  - Reflects only the selected channel; no head-of-line blocking across channels.
- Load_k = in_valid && in_ready && (select==k).
  - On load, the register captures In and ok_valid=1 from the next cycle.
  - Latency is exactly 1 cycle from acceptance to ok_valid.
- Simultaneous drain and load on the same channel: the new beat replaces the old one, ok_valid stays 1, and there is no bubble cycle.
- The unselected channel's data, valid and counter are unaffected by a load to the other channel.
- While ok_valid=1 && ok_ready=0, ok is stable.
- in_valid=0: select and In are ignored; in_ready is still driven per the rule above.
- Counters:
  - cntk increments by 1 on each Load_k.
  - Wraps modulo 2^CNT_W with no saturation.
  - Updates in the same edge as the data load.
- Data out of held channels when ok_valid=0: retains the last loaded value. Consumers must not rely on it.

Optional Feature:
- Macro DEMUX2_64BIT_CNT_EN.
- Defined: cnt0/cnt1 counters are implemented as described.
- Not defined: counter registers are omitted; cnt0 and cnt1 are tied to 0. All data and handshake behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> o0_valid=o1_valid=0, o0=o1=0, cnt0=cnt1=0, in_ready=1.
- Basic route: In=64'd7, select=0, in_valid for one cycle, o0_ready=1 ->
  - next cycle o0=7, o0_valid=1, o1_valid=0, cnt0=1.
  - following cycle o0_valid=0.
  - Repeat with In=64'd12, select=1 -> o1=12, cnt1=1.
- Backpressure, no head-of-line block:
  - With o1_ready=0, send 12 to channel 1 -> o1_valid=1, o1=12 held.
  - Second beat select=1 -> in_ready=0, not accepted, cnt1 unchanged.
  - Switch to In=7, select=0 -> in_ready=1, o0=7 next cycle.
- Drain and load same cycle: o0 holds 7, o0_ready=1, new beat 64'hFFFF_FFFF_FFFF_FFFF with select=0 -> next cycle o0=all-ones, o0_valid stays 1, cnt0 increments by 1.
- Counter wrap (CNT_W=4, macro defined): 16 accepted beats into channel 1 -> cnt1=0, cnt0 unchanged. Without the macro -> cnt0=cnt1=0 throughout.
- Reset mid-operation: o1_valid=1 holding 12, drop rst_n between clock edges -> o1_valid=0, o1=0, cnt1=0 immediately without waiting for a clock edge. After release, a new beat behaves as in the basic route scenario.
